// File: rtl/dred_pkg.sv
// Shared types, defaults and helpers for the D-reduced autosymmetric expander
// and the restriction-side checker.
package dred_pkg;

  localparam int N_DEF     = 6;
  localparam int K_MAX_DEF = 6;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // One output bit of the linear projection: parity of the selected x bits.
  function automatic logic xor_reduce_masked(input logic [31:0] x, input logic [31:0] mask);
    return ^(x & mask);
  endfunction

endpackage

// File: rtl/dred_lambda.sv
// Linear projection y = lambda(x): y_j is the parity of x under mask row j,
// forced to zero for rows at or above k.
module dred_lambda
  import dred_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int K_MAX = K_MAX_DEF
) (
  input  logic [N-1:0]       x,
  input  logic [K_MAX*N-1:0] masks,
  input  logic [2:0]         k,
  output logic [K_MAX-1:0]   y
);

  always_comb begin
    y = '0;
    for (int j = 0; j < K_MAX; j++) begin
      if (3'(j) < k) y[j] = xor_reduce_masked(32'(x), 32'(masks[j*N +: N]));
    end
  end

endmodule

// File: rtl/dred_expander.sv
// Streams the full 2^N-entry truth table of f(x) = f_k(lambda(x)) ^ inv,
// one minterm per beat, from a latched reduced configuration.
module dred_expander
  import dred_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int K_MAX = K_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [2:0]            cfg_k,
  input  logic [K_MAX*N-1:0]    cfg_masks,
  input  logic [(1<<K_MAX)-1:0] cfg_tt,
  input  logic                  cfg_inv,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_data,
  output logic [N-1:0]          out_addr,
  output logic                  out_last,
  output logic                  busy
);

  localparam int TT_W = 1 << K_MAX;

  state_t              state;
  logic [2:0]          k_r;
  logic [K_MAX*N-1:0]  masks_r;
  logic [TT_W-1:0]     tt_r;
  logic                inv_r;
  logic [N-1:0]        x;

  logic [2:0]          k_sat;
  logic [K_MAX-1:0]    y;
  logic [K_MAX*N-1:0]  masks_used;
  logic [TT_W-1:0]     tt_used;
  logic                cfg_hs;
  logic                advance;
  logic                x_last;

  assign k_sat   = (cfg_k > 3'(K_MAX)) ? 3'(K_MAX) : cfg_k;
  assign cfg_hs  = cfg_valid & cfg_ready;
  assign advance = !out_valid | out_ready;
  assign x_last  = &x;
  assign busy    = (state != ST_IDLE);

  // Scrub rows and table entries the reduced function cannot reach.
  always_comb begin
    masks_used = masks_r;
    tt_used    = tt_r;
    for (int j = 0; j < K_MAX; j++) begin
      if (3'(j) >= k_r) masks_used[j*N +: N] = '0;
    end
    for (int i = 0; i < TT_W; i++) begin
      if (i >= (1 << k_r)) tt_used[i] = 1'b0;
    end
  end

  dred_lambda #(.N(N), .K_MAX(K_MAX)) u_lambda (
    .x     (x),
    .masks (masks_r),
    .k     (k_r),
    .y     (y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cfg_ready <= 1'b0;
      k_r       <= '0;
      masks_r   <= '0;
      tt_r      <= '0;
      inv_r     <= 1'b0;
      x         <= '0;
      out_valid <= 1'b0;
      out_data  <= 1'b0;
      out_addr  <= '0;
      out_last  <= 1'b0;
    end else begin
      cfg_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_hs) begin
            k_r     <= k_sat;
            masks_r <= cfg_masks;
            tt_r    <= cfg_tt;
            inv_r   <= cfg_inv;
            state   <= ST_LOAD;
          end else begin
            cfg_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          masks_r <= masks_used;
          tt_r    <= tt_used;
          x       <= '0;
          state   <= ST_RUN;
        end
        ST_RUN: begin
          if (advance) begin
            out_valid <= 1'b1;
            out_data  <= tt_r[y] ^ inv_r;
            out_addr  <= x;
            out_last  <= x_last;
            // The terminal minterm ends the run; the counter never wraps.
            if (x_last) state <= ST_DRAIN;
            else        x     <= x + N'(1);
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
